// File: rtl/sram_io_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_io_ctrl_if
//   Bundles the bit-serial host handshake and the 512x8 SRAM bus seen by
//   sram_io_ctrl. The host (or bench) side uses the master modport. The
//   controller uses the slave modport.
//
//   Host -> controller : BGN, LOAD_N, CTRL[1:0], SI
//   SRAM -> controller : PI[MEMORY_DATA_WIDTH-1:0]   (registered read data)
//   Controller -> host : RDY, SO
//   Controller -> SRAM : CEN (active-low), D_WE (active-low),
//                        A[MEMORY_ADDR_WIDTH-1:0], PO[MEMORY_DATA_WIDTH-1:0]
// ---------------------------------------------------------------------------
interface sram_io_ctrl_if #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9
);
  logic                         BGN;
  logic                         LOAD_N;
  logic [1:0]                   CTRL;
  logic                         SI;
  logic [MEMORY_DATA_WIDTH-1:0] PI;
  logic                         RDY;
  logic                         D_WE;
  logic                         CEN;
  logic                         SO;
  logic [MEMORY_ADDR_WIDTH-1:0] A;
  logic [MEMORY_DATA_WIDTH-1:0] PO;

  modport master (
    output BGN, LOAD_N, CTRL, SI, PI,
    input  RDY, D_WE, CEN, SO, A, PO
  );

  modport slave (
    input  BGN, LOAD_N, CTRL, SI, PI,
    output RDY, D_WE, CEN, SO, A, PO
  );
endinterface

// File: rtl/sram_io_ctrl.sv
// ---------------------------------------------------------------------------
// sram_io_ctrl
//   Bridge between a bit-serial host link and a 512x8 synchronous SRAM. A
//   17-bit register holds {addr[8:0], data[7:0]}. The host shifts a word in
//   LSB first (data LSB first). It then commands an SRAM write or read with the
//   BGN / LOAD_N / RDY handshake. A read returns its byte in the data field of
//   the register, so the host can shift it back out.
//
// Ports
//   CLK     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   bus     slave modport of sram_io_ctrl_if:
//             BGN    in   operation enable, held high for the whole operation
//             LOAD_N in   active-low start strobe, sampled with BGN in IDLE
//             CTRL   in   00 shift-in, 01 read, 11 write, 10 shift-out
//             SI     in   serial data in, LSB first
//             PI     in   SRAM read data (valid the cycle after the read edge)
//             RDY    out  operation complete (high in DONE)
//             D_WE   out  SRAM write enable, active-low
//             CEN    out  SRAM chip enable, active-low
//             SO     out  reg_bits[0]
//             A      out  reg_bits[16:8]
//             PO     out  reg_bits[7:0]
//
// Build option
//   SRAM_IO_CTRL_SHIFT_OUT_EN : when defined, mode 10 rotates the register
//   through SO for 17 edges and leaves it restored. When undefined, mode 10
//   completes at once with no register change.
// ---------------------------------------------------------------------------
module sram_io_ctrl #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9
) (
  input  logic           CLK,
  input  logic           rst_n,
  sram_io_ctrl_if.slave  bus
);

  localparam int REG_BITS_WIDTH = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int CNT_W          = $clog2(REG_BITS_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(REG_BITS_WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_SHIFT_IN  = 2'b00,
    MODE_READ      = 2'b01,
    MODE_SHIFT_OUT = 2'b10,
    MODE_WRITE     = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_MEM   = 3'd3,
    ST_CAPT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  state_e                    state_q;
  state_e                    state_d;
  mode_e                     ctrl_q;
  logic [REG_BITS_WIDTH-1:0] reg_bits;
  logic [CNT_W-1:0]          bit_cnt;

  logic start;
  logic rdy_c;
  logic cen_c;
  logic d_we_c;

  // LOAD_N is only looked at in IDLE, so later toggles cannot restart anything.
  assign start = bus.BGN && !bus.LOAD_N;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and SRAM strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rdy_c   = 1'b0;
    cen_c   = 1'b1;
    d_we_c  = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          unique case (mode_e'(bus.CTRL))
            MODE_SHIFT_IN:  state_d = ST_PREP;
            MODE_READ:      state_d = ST_MEM;
            MODE_WRITE:     state_d = ST_MEM;
`ifdef SRAM_IO_CTRL_SHIFT_OUT_EN
            MODE_SHIFT_OUT: state_d = ST_PREP;
`else
            MODE_SHIFT_OUT: state_d = ST_DONE;
`endif
            default:        state_d = ST_IDLE;
          endcase
        end
      end

      // One dead cycle gives the host time to present the first SI bit.
      ST_PREP: begin
        state_d = bus.BGN ? ST_SHIFT : ST_IDLE;
      end

      ST_SHIFT: begin
        if (!bus.BGN) begin
          state_d = ST_IDLE;
        end else if (bit_cnt == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end

      // The SRAM samples CEN/D_WE on the edge that ends this state. Once that
      // edge passes, an abort cannot undo the access.
      ST_MEM: begin
        cen_c  = 1'b0;
        d_we_c = (ctrl_q == MODE_WRITE) ? 1'b0 : 1'b1;
        if (!bus.BGN) begin
          state_d = ST_IDLE;
        end else if (ctrl_q == MODE_READ) begin
          state_d = ST_CAPT;
        end else begin
          state_d = ST_DONE;
        end
      end

      // Registered SRAM read data is valid on PI during this cycle.
      ST_CAPT: begin
        state_d = bus.BGN ? ST_DONE : ST_IDLE;
      end

      ST_DONE: begin
        rdy_c = 1'b1;
        if (!bus.BGN) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Mode latch, bit counter and shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= MODE_SHIFT_IN;
      bit_cnt  <= '0;
      reg_bits <= '0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        ctrl_q <= mode_e'(bus.CTRL);
      end

      // The counter counts only while bits actually move. It sits at zero
      // otherwise, so every operation starts from a clean count.
      if (state_q == ST_SHIFT && bus.BGN) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        bit_cnt <= '0;
      end

      if (state_q == ST_SHIFT && bus.BGN) begin
`ifdef SRAM_IO_CTRL_SHIFT_OUT_EN
        if (ctrl_q == MODE_SHIFT_OUT) begin
          // Rotation: after exactly 17 edges the word is back in place.
          reg_bits <= {reg_bits[0], reg_bits[REG_BITS_WIDTH-1:1]};
        end else begin
          reg_bits <= {bus.SI, reg_bits[REG_BITS_WIDTH-1:1]};
        end
`else
        reg_bits <= {bus.SI, reg_bits[REG_BITS_WIDTH-1:1]};
`endif
      end else if (state_q == ST_CAPT && bus.BGN) begin
        // Only the data field is replaced. The address stays for re-reads.
        reg_bits[MEMORY_DATA_WIDTH-1:0] <= bus.PI;
      end
    end
  end

  assign bus.RDY  = rdy_c;
  assign bus.CEN  = cen_c;
  assign bus.D_WE = d_we_c;
  assign bus.SO   = reg_bits[0];
  assign bus.A    = reg_bits[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
  assign bus.PO   = reg_bits[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_sram_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_io_ctrl
//   Directed bench for sram_io_ctrl with a behavioural 512x8 synchronous
//   SRAM. Inputs change on the falling edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_sram_io_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sram_io_ctrl_if #(.MEMORY_DATA_WIDTH(8), .MEMORY_ADDR_WIDTH(9)) bus ();

  sram_io_ctrl #(
    .MEMORY_DATA_WIDTH(8),
    .MEMORY_ADDR_WIDTH(9)
  ) dut (
    .CLK  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural SRAM: CEN low enables it, D_WE low writes, and read data is registered.
  logic [7:0] mem [0:511];
  logic [7:0] rd_q;

  always @(posedge clk) begin
    if (!bus.CEN) begin
      if (!bus.D_WE) mem[bus.A] <= bus.PO;
      else           rd_q       <= mem[bus.A];
    end
  end

  assign bus.PI = rd_q;

  // Strobe activity counters, sampled mid-cycle.
  int cen_cnt = 0;
  int we_cnt  = 0;
  int rdy_cnt = 0;

  always @(negedge clk) begin
    if (!bus.CEN)  cen_cnt++;
    if (!bus.D_WE) we_cnt++;
    if (bus.RDY)   rdy_cnt++;
  end

  int   vectors     = 0;
  int   miscompares = 0;
  logic rdy_before_last;

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers (no checks) ----------------
  task automatic start_op(input logic [1:0] mode);
    @(negedge clk);
    bus.BGN    = 1'b1;
    bus.LOAD_N = 1'b0;
    bus.CTRL   = mode;
    @(negedge clk);
    bus.LOAD_N = 1'b1;
  endtask

  // Leaves the bench at the falling edge after the 17th shift edge, with BGN still high.
  task automatic shift_in(input logic [8:0] addr, input logic [7:0] data);
    logic [16:0] w;
    w = {addr, data};
    start_op(2'b00);
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      bus.SI = w[i];
      if (i == 16) rdy_before_last = bus.RDY;
      @(negedge clk);
    end
  endtask

  task automatic end_op;
    bus.BGN = 1'b0;
    @(negedge clk);
  endtask

  task automatic mem_op(input logic [1:0] mode, output bit got_rdy, output int lat,
                        output int cen_d, output int we_d);
    int c0;
    int w0;
    c0 = cen_cnt;
    w0 = we_cnt;
    got_rdy = 1'b0;
    lat = -1;
    start_op(mode);
    for (int k = 0; k < 8; k++) begin
      if (bus.RDY) begin
        got_rdy = 1'b1;
        lat = k;
        break;
      end
      @(negedge clk);
    end
    end_op;
    cen_d = cen_cnt - c0;
    we_d  = we_cnt - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    bus.BGN = 1'b0; bus.LOAD_N = 1'b1; bus.CTRL = 2'b00; bus.SI = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.RDY !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b expected 0", bus.RDY); end
    vectors++; if (bus.CEN !== 1'b1) begin miscompares++; $display("FAIL reset_cen: got %b expected 1", bus.CEN); end
    vectors++; if (bus.D_WE !== 1'b1) begin miscompares++; $display("FAIL reset_dwe: got %b expected 1", bus.D_WE); end
    vectors++; if (bus.SO !== 1'b0) begin miscompares++; $display("FAIL reset_so: got %b expected 0", bus.SO); end
    vectors++; if ({bus.A, bus.PO} !== 17'h0) begin miscompares++; $display("FAIL reset_reg: got %h expected 0", {bus.A, bus.PO}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.RDY !== 1'b0) begin miscompares++; $display("FAIL idle_rdy: got %b expected 0", bus.RDY); end
  endtask

  task automatic test_shift_in;
    shift_in(9'h020, 8'hA5);
    vectors++; if (rdy_before_last !== 1'b0) begin miscompares++; $display("FAIL shift_rdy_early: got %b expected 0", rdy_before_last); end
    vectors++; if (bus.RDY !== 1'b1) begin miscompares++; $display("FAIL shift_rdy: got %b expected 1", bus.RDY); end
    vectors++; if (bus.A !== 9'h020) begin miscompares++; $display("FAIL shift_addr: got %h expected 020", bus.A); end
    vectors++; if (bus.PO !== 8'hA5) begin miscompares++; $display("FAIL shift_data: got %h expected a5", bus.PO); end
    vectors++; if (bus.SO !== 1'b1) begin miscompares++; $display("FAIL shift_so: got %b expected 1", bus.SO); end
    // Register frozen in DONE and LOAD_N ignored while BGN stays high.
    bus.SI = 1'b0;
    bus.LOAD_N = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.RDY !== 1'b1) begin miscompares++; $display("FAIL done_hold_rdy: got %b expected 1", bus.RDY); end
    vectors++; if ({bus.A, bus.PO} !== {9'h020, 8'hA5}) begin miscompares++; $display("FAIL done_frozen: got %h expected %h", {bus.A, bus.PO}, {9'h020, 8'hA5}); end
    bus.LOAD_N = 1'b1;
    end_op;
    vectors++; if (bus.RDY !== 1'b0) begin miscompares++; $display("FAIL done_release: got %b expected 0", bus.RDY); end
  endtask

  task automatic test_write;
    bit got; int lat; int cd; int wd;
    mem_op(2'b11, got, lat, cd, wd);
    vectors++; if (got !== 1'b1 || lat != 1) begin miscompares++; $display("FAIL write_rdy: got rdy=%b lat=%0d expected rdy=1 lat=1", got, lat); end
    vectors++; if (cd != 1) begin miscompares++; $display("FAIL write_cen_cycles: got %0d expected 1", cd); end
    vectors++; if (wd != 1) begin miscompares++; $display("FAIL write_we_cycles: got %0d expected 1", wd); end
    vectors++; if (mem[9'h020] !== 8'hA5) begin miscompares++; $display("FAIL write_mem: got %h expected a5", mem[9'h020]); end
  endtask

  task automatic test_read;
    bit got; int lat; int cd; int wd;
    shift_in(9'h020, 8'h00);
    end_op;
    mem_op(2'b01, got, lat, cd, wd);
    vectors++; if (got !== 1'b1 || lat != 2) begin miscompares++; $display("FAIL read_rdy: got rdy=%b lat=%0d expected rdy=1 lat=2", got, lat); end
    vectors++; if (cd != 1) begin miscompares++; $display("FAIL read_cen_cycles: got %0d expected 1", cd); end
    vectors++; if (wd != 0) begin miscompares++; $display("FAIL read_we_cycles: got %0d expected 0", wd); end
    vectors++; if (bus.PO !== 8'hA5) begin miscompares++; $display("FAIL read_data: got %h expected a5", bus.PO); end
    vectors++; if (bus.A !== 9'h020) begin miscompares++; $display("FAIL read_addr: got %h expected 020", bus.A); end
  endtask

  task automatic test_back_to_back;
    bit got; int lat; int cd; int wd;
    logic [8:0] a;
    logic [7:0] d;
    for (int n = 0; n < 21; n++) begin
      a = (n < 14) ? 9'(32 + n) : (n < 20) ? 9'(n - 14) : 9'h1FF;
      d = 8'((a * 29) + 7);
      shift_in(a, d);
      end_op;
      mem_op(2'b11, got, lat, cd, wd);
      vectors++; if (mem[a] !== d || got !== 1'b1) begin miscompares++; $display("FAIL b2b_write a=%h: got %h rdy=%b expected %h rdy=1", a, mem[a], got, d); end
    end
    for (int n = 0; n < 21; n++) begin
      a = (n < 14) ? 9'(32 + n) : (n < 20) ? 9'(n - 14) : 9'h1FF;
      d = 8'((a * 29) + 7);
      shift_in(a, 8'h00);
      end_op;
      mem_op(2'b01, got, lat, cd, wd);
      vectors++; if ({bus.A, bus.PO} !== {a, d} || got !== 1'b1) begin miscompares++; $display("FAIL b2b_read a=%h: got %h expected %h", a, {bus.A, bus.PO}, {a, d}); end
    end
  endtask

  task automatic test_abort;
    logic [16:0] w;
    logic [16:0] exp_w;
    int r0;
    w = {9'h0F0, 8'h0F};
    shift_in(9'h0F0, 8'h0F);
    end_op;
    r0 = rdy_cnt;
    start_op(2'b00);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.SI = 1'b1;
      @(negedge clk);
    end
    bus.BGN = 1'b0;
    repeat (3) @(negedge clk);
    exp_w = {5'b11111, w[16:5]};
    vectors++; if (rdy_cnt != r0) begin miscompares++; $display("FAIL abort_no_rdy: got %0d rdy cycles expected 0", rdy_cnt - r0); end
    vectors++; if ({bus.A, bus.PO} !== exp_w) begin miscompares++; $display("FAIL abort_partial: got %h expected %h", {bus.A, bus.PO}, exp_w); end
  endtask

  task automatic test_reset_mid;
    start_op(2'b00);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      bus.SI = 1'b1;
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.RDY !== 1'b0 || bus.CEN !== 1'b1 || bus.D_WE !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ctrl: got rdy=%b cen=%b dwe=%b expected 0 1 1", bus.RDY, bus.CEN, bus.D_WE); end
    vectors++; if ({bus.A, bus.PO} !== 17'h0) begin miscompares++; $display("FAIL rst_mid_reg: got %h expected 0", {bus.A, bus.PO}); end
    bus.BGN = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    shift_in(9'h1AB, 8'hC3);
    vectors++; if (bus.RDY !== 1'b1 || {bus.A, bus.PO} !== {9'h1AB, 8'hC3}) begin miscompares++; $display("FAIL rst_mid_reload: got rdy=%b reg=%h expected 1 %h", bus.RDY, {bus.A, bus.PO}, {9'h1AB, 8'hC3}); end
    end_op;
  endtask

  task automatic test_shift_out;
    logic [16:0] w;
    w = {9'h155, 8'h3C};
    shift_in(9'h155, 8'h3C);
    end_op;
`ifdef SRAM_IO_CTRL_SHIFT_OUT_EN
    start_op(2'b10);
    @(negedge clk);
    for (int k = 0; k < 17; k++) begin
      vectors++; if (bus.SO !== w[k]) begin miscompares++; $display("FAIL so_bit%0d: got %b expected %b", k, bus.SO, w[k]); end
      @(negedge clk);
    end
    vectors++; if (bus.RDY !== 1'b1) begin miscompares++; $display("FAIL so_rdy: got %b expected 1", bus.RDY); end
    vectors++; if ({bus.A, bus.PO} !== w) begin miscompares++; $display("FAIL so_restore: got %h expected %h", {bus.A, bus.PO}, w); end
    end_op;
`else
    begin
      bit got; int lat; int cd; int wd;
      mem_op(2'b10, got, lat, cd, wd);
      vectors++; if (got !== 1'b1 || lat != 0) begin miscompares++; $display("FAIL so_off_rdy: got rdy=%b lat=%0d expected rdy=1 lat=0", got, lat); end
      vectors++; if (cd != 0) begin miscompares++; $display("FAIL so_off_cen: got %0d expected 0", cd); end
      vectors++; if ({bus.A, bus.PO} !== w) begin miscompares++; $display("FAIL so_off_reg: got %h expected %h", {bus.A, bus.PO}, w); end
      vectors++; if (bus.SO !== w[0]) begin miscompares++; $display("FAIL so_off_so: got %b expected %b", bus.SO, w[0]); end
    end
`endif
  endtask

  initial begin
    test_reset;
    test_shift_in;
    test_write;
    test_read;
    test_back_to_back;
    test_abort;
    test_reset_mid;
    test_shift_out;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
